// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder cell: sum and carry of two input bits.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder_full_adder_cell.sv
// Combinational full-adder slice built from two half_adder cells and an OR of their carries.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s0),
    .c_o (c0)
  );

  half_adder u_ha1 (
    .a_i (s0),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c1)
  );

  // Both half-adder carries can never be 1 together, so OR equals the full-adder carry.
  assign c_o = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts two WIDTH-bit operands, adds them LSB-first one bit per cycle
// through a single full-adder slice, and presents the registered sum and carry via valid/ready.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             sum_bit_d;
  logic             c_d;

  full_adder_cell u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (c_q),
    .s_o (sum_bit_d),
    .c_o (c_d)
  );

  // NOTE: every register here uses <= so all state updates on an edge see pre-edge values;
  // a blocking assignment would let the shift registers consume their own new contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            sum_sh_q   <= '0;
            c_q        <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ADD;
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        ADD: begin
          sum_sh_q <= {sum_bit_d, sum_sh_q[WIDTH-1:1]};
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          c_q      <= c_d;
          if (cnt_q == LAST_CNT) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          // in_ready is raised on the same edge so the next accept can follow immediately.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_sh_q;
  assign carry_out = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: drivers push expected {carry,sum} on accept,
// a negedge monitor pops and compares on every output handshake.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         carry_out;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W:0]   exp_q[$];
  logic [W:0]   mon_e;
  bit           rnd_stall = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Inputs only change at posedge+1, so values seen at negedge decide the next edge's handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum", sum, mon_e[W-1:0]);
        check("carry_out", carry_out, mon_e[W]);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rnd_stall) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W:0] want, input bit expect_res);
    int t = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    if (expect_res) exp_q.push_back(want);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int t;

    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_carry", carry_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_first_edge", in_ready, 0);
    @(posedge clk);
    #1;
    check("in_ready_after_release", in_ready, 1);

    // 0+0: exact latency and in_ready return
    send(8'h00, 8'h00, 9'h000, 1'b1);
    repeat (W - 1) @(posedge clk);
    #1;
    check("latency_early", out_valid, 0);
    @(posedge clk);
    #1;
    check("latency_exact", out_valid, 1);
    @(posedge clk);
    #1;
    check("in_ready_after_out", in_ready, 1);
    check("out_valid_cleared", out_valid, 0);

    // overflow then a no-carry add; carry must not leak
    send(8'hFF, 8'h01, 9'h100, 1'b1);
    send(8'hA5, 8'h5A, 9'h0FF, 1'b1);
    wait_drain();

    // output stall: result held stable, no new accept
    out_ready = 1'b0;
    send(8'h80, 8'h80, 9'h100, 1'b1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("stall_out_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_sum", sum, 8'h00);
      check("stall_carry", carry_out, 1);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain();

    // stray in_valid during ADD must be ignored
    send(8'h0F, 8'h01, 9'h010, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 8'h11;
    b = 8'h22;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain();
    repeat (W + 4) @(posedge clk);
    #1;
    check("no_ghost_out_valid", out_valid, 0);
    check("no_ghost_in_ready", in_ready, 1);

    // reset in the middle of ADD aborts the operation
    send(8'h7F, 8'h7F, 9'h0FE, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_carry", carry_out, 0);
    check("abort_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h7F, 8'h7F, 9'h0FE, 1'b1);
    wait_drain();

    // random operands with random output stalls
    rnd_stall = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      send(ra, rb, {1'b0, ra} + {1'b0, rb}, 1'b1);
    end
    rnd_stall = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder that feeds the existing half_adder cell one bit pair per cycle. It adds two WIDTH-bit operands LSB-first over WIDTH cycles, holding the running carry in a flip-flop. Operands enter through a valid/ready handshake and the result leaves through another. It is the sequential wrapper around half_adder, for area-constrained datapaths.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 2.
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands a/b present.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
out_valid  output  1  sum/carry_out valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  A+B modulo 2^WIDTH.
carry_out  output  1  carry out of the MSB.

Behaviour:
- Reset: one clock; asynchronous active-low reset (rst_n, clk). While rst_n=0: state=IDLE, shift registers, carry flop and bit counter all 0, sum=0, carry_out=0, out_valid=0, in_ready=0. in_ready rises the first clock edge after release.
- Handshake: a transfer happens on a rising edge where valid && ready are both 1. No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- State machine (registered): IDLE, ADD, DONE.
- IDLE: in_ready=1. On accept: a_sh<=a, b_sh<=b, c<=0, cnt<=0, sum_sh<=0, go to ADD. Otherwise stay.
- ADD: in_ready=0, out_valid=0. Each cycle:
  - Full-add bit = a_sh[0]^b_sh[0]^c.
  - cout = two half_adder stages ORed.
  - sum_sh <= {bit, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right with zero fill; c <= cout; cnt++.
  - When cnt==WIDTH-1, that edge is the last bit; go to DONE.
- DONE: out_valid=1; sum=sum_sh, carry_out=c, both held stable until the result is taken. On out_ready, go to IDLE.
- sum and carry_out are registered. They keep their last value after the handshake; outside DONE they are don't-care for consumers.
- Latency: accept at edge k gives out_valid=1 after edge k+WIDTH. Minimum spacing between accepts is WIDTH+2 cycles.
- in_valid during ADD/DONE is ignored; the upstream producer must hold it.
- out_ready while not in DONE has no effect.
- Reset mid-ADD or mid-DONE aborts the operation. All outputs return to reset values and the result is lost.
- Overflow: carry_out=1 exactly when a+b >= 2^WIDTH; sum wraps.
- cnt never exceeds WIDTH-1; no wrap is reachable.

Decomposition:
- Package serial_adder_pkg: state encoding localparams (IDLE=2'd0, ADD=2'd1, DONE=2'd2) and default WIDTH.
- One sub-module, full_adder_cell: two half_adder instances plus an OR, purely combinational, instantiated once for the bit slice.
- FSM, counter and shift registers stay in serial_adder.

Test Plan:
1. WIDTH=8, a=0x00, b=0x00, out_ready=1 -> out_valid exactly 8 cycles after accept; sum=0x00, carry_out=0; in_ready=1 the cycle after the output handshake.
2. a=0xFF, b=0x01 -> sum=0x00, carry_out=1. Then a=0xA5, b=0x5A -> sum=0xFF, carry_out=0; no carry leaks from the previous operation.
3. a=0x80, b=0x80, out_ready held 0 for 5 cycles after out_valid -> sum=0x00, carry_out=1 stable all 5 cycles; in_ready=0 until out_ready=1.
4. in_valid pulsed with a=0x11, b=0x22 during ADD of 0x0F+0x01 -> result 0x10, carry_out=0; the second operand pair is not captured.
5. rst_n driven low on the 4th ADD cycle of 0x7F+0x7F -> out_valid=0, sum=0, carry_out=0, in_ready=0 immediately. After release, 0x7F+0x7F completes with sum=0xFE, carry_out=0.
6. Random back-to-back operands (≥1000), random out_ready stalls -> every result matches a+b against a reference model; no handshake lost or duplicated.
